// File: rtl/grid_pr_slot_nch.sv
// Grid slot: NUM_IN buffered input channels feeding a runtime-configurable op unit.
// One result fires per cycle once every enabled channel has data and the output can take it.
module grid_pr_slot_nch #(
    parameter int unsigned NUM_IN     = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         cfg_valid,
    input  logic [3:0]                   cfg_op,
    input  logic [NUM_IN-1:0]            cfg_mask,
    input  logic [DATA_WIDTH-1:0]        cfg_acc_init,
    output logic                         cfg_ready,
    output logic                         cfg_err,
    input  logic                         flush,
    output logic [31:0]                  fire_count
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_PASS   = 4'd0;
    localparam logic [3:0] OP_ADD    = 4'd1;
    localparam logic [3:0] OP_SUB    = 4'd2;
    localparam logic [3:0] OP_AND    = 4'd3;
    localparam logic [3:0] OP_OR     = 4'd4;
    localparam logic [3:0] OP_XOR    = 4'd5;
    localparam logic [3:0] OP_SLL    = 4'd6;
    localparam logic [3:0] OP_SRL    = 4'd7;
    localparam logic [3:0] OP_ACC    = 4'd8;
    localparam logic [3:0] OP_SUMALL = 4'd9;

    logic [DATA_WIDTH-1:0] r_mem  [NUM_IN][FIFO_DEPTH];
    logic [PW-1:0]         r_wptr [NUM_IN];
    logic [PW-1:0]         r_rptr [NUM_IN];
    logic [CW-1:0]         r_cnt  [NUM_IN];
    logic [3:0]            r_op;
    logic [NUM_IN-1:0]     r_mask;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_cfgd;
    logic                  r_out_valid;
    logic                  r_cfg_err;
    logic [31:0]           r_fire_cnt;

    logic [NUM_IN-1:0]     w_push;
    logic [NUM_IN-1:0]     w_pop;
    logic [NUM_IN-1:0]     w_full;
    logic [NUM_IN-1:0]     w_nonempty;
    logic [DATA_WIDTH-1:0] w_head [NUM_IN];
    logic                  w_operands_rdy;
    logic                  w_fifos_empty;
    logic                  w_fire;
    logic                  w_cfg_legal;
    logic                  w_cfg_take;
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic [DATA_WIDTH-1:0] w_sum;
    logic [DATA_WIDTH-1:0] w_acc_next;
    logic [DATA_WIDTH-1:0] w_result;
    logic [SW-1:0]         w_shamt;

    // Per-channel FIFO status; disabled channels always accept and discard.
    always_comb begin
        w_operands_rdy = 1'b1;
        w_fifos_empty  = 1'b1;
        w_sum          = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_nonempty[i] = (r_cnt[i] != '0);
            w_full[i]     = (r_cnt[i] == CW'(FIFO_DEPTH));
            in_ready[i]   = !r_mask[i] || !w_full[i];
            w_push[i]     = in_valid[i] && r_mask[i] && !w_full[i] && !flush;
            w_head[i]     = r_mem[i][r_rptr[i]];
            if (r_mask[i] && !w_nonempty[i]) w_operands_rdy = 1'b0;
            if (w_nonempty[i]) w_fifos_empty = 1'b0;
            if (r_mask[i]) w_sum = w_sum + w_head[i];
        end
    end

    assign w_fire     = r_cfgd && w_operands_rdy && (!r_out_valid || out_ready) && !flush;
    assign w_pop      = {NUM_IN{w_fire}} & r_mask;
    assign w_a        = w_head[0];
    assign w_b        = w_head[1];
    assign w_shamt    = w_b[SW-1:0];
    assign w_acc_next = r_acc + w_a;

    always_comb begin
        w_result = w_a;
        case (r_op)
            OP_PASS:   w_result = w_a;
            OP_ADD:    w_result = w_a + w_b;
            OP_SUB:    w_result = w_a - w_b;
            OP_AND:    w_result = w_a & w_b;
            OP_OR:     w_result = w_a | w_b;
            OP_XOR:    w_result = w_a ^ w_b;
            OP_SLL:    w_result = w_a << w_shamt;
            OP_SRL:    w_result = w_a >> w_shamt;
            OP_ACC:    w_result = w_acc_next;
            OP_SUMALL: w_result = w_sum;
            default:   w_result = w_a;
        endcase
    end

    // Two-operand ops need both a and b; PASS/ACC only need a.
    always_comb begin
        w_cfg_legal = 1'b0;
        case (cfg_op)
            OP_PASS, OP_ACC: w_cfg_legal = cfg_mask[0];
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SLL, OP_SRL: w_cfg_legal = cfg_mask[0] && cfg_mask[1];
            OP_SUMALL:       w_cfg_legal = |cfg_mask;
            default:         w_cfg_legal = 1'b0;
        endcase
    end

    assign cfg_ready  = w_fifos_empty && !r_out_valid;
    assign w_cfg_take = cfg_valid && cfg_ready;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_push[i]) r_mem[i][r_wptr[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_IN; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_op        <= OP_PASS;
            r_mask      <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_cfgd      <= 1'b0;
            r_out_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_fire_cnt  <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (flush) begin
                    r_wptr[i] <= '0;
                    r_rptr[i] <= '0;
                    r_cnt[i]  <= '0;
                end else begin
                    if (w_push[i]) r_wptr[i] <= r_wptr[i] + PW'(1);
                    if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PW'(1);
                    r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
                end
            end

            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_fire) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_result;
                r_fire_cnt  <= r_fire_cnt + 32'd1;
                if (r_op == OP_ACC) r_acc <= w_acc_next;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            r_cfg_err <= w_cfg_take && !w_cfg_legal;
            if (w_cfg_take && w_cfg_legal) begin
                r_op   <= cfg_op;
                r_mask <= cfg_mask;
                r_acc  <= cfg_acc_init;
                r_cfgd <= 1'b1;
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign cfg_err    = r_cfg_err;
    assign fire_count = r_fire_cnt;

endmodule

// File: doc/grid_pr_slot_nch.md
Name: grid_pr_slot_nch

Overview:
- Parametrised next-generation grid slot for the RCA grid: NUM_IN independently buffered input channels feeding a built-in, runtime-configurable operation unit (replaces the fixed two-input empty PR module).
- Firing is dataflow: one result per cycle when every enabled input FIFO holds data and the output register can accept.
- Adds things the two-input slot lacks: runtime op/mask configuration, an accumulate mode with internal state, ready/valid backpressure on inputs and output, flush, and a fire counter.

Parameters:
- NUM_IN, 2, number of input channels (2..4).
- DATA_WIDTH, 32, datapath width (XLEN in the core).
- FIFO_DEPTH, 4, entries per input FIFO (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- in_data  in  NUM_IN*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  NUM_IN  per-channel data valid.
- in_ready  out  NUM_IN  per-channel accept.
- out_data  out  DATA_WIDTH  result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- cfg_valid  in  1  configuration request.
- cfg_op  in  4  operation code.
- cfg_mask  in  NUM_IN  enabled-input mask.
- cfg_acc_init  in  DATA_WIDTH  accumulator initial value.
- cfg_ready  out  1  slot idle; config accepted this cycle if cfg_valid.
- cfg_err  out  1  one-cycle pulse on rejected config.
- flush  in  1  synchronous flush of queued data.
- fire_count  out  32  results produced since reset; wraps.

Behaviour:
- Reset (async assert): all FIFOs empty, out_valid=0, out_data=0, op=PASS, mask=0, acc=0, configured=0, cfg_err=0, fire_count=0.
- in_ready[i]:
  - mask[i]=0: in_ready[i]=1 and pushed data is discarded.
  - mask[i]=1: in_ready[i]=!full[i].
  - Push when in_valid[i] && in_ready[i].
  - FIFOs are not fall-through: data pushed in cycle N is poppable in N+1 at the earliest.
- fire = configured && all enabled FIFOs non-empty && (!out_valid || out_ready) && !flush.
  - On fire: pop every enabled FIFO, register result into out_data, set out_valid next cycle, increment fire_count.
  - Minimum latency from input push to out_valid is 2 cycles.
- Output handshake:
  - out_valid && out_ready with no fire: out_valid clears.
  - Fire and consume in the same cycle: out_valid stays 1 and out_data updates.
  - out_data holds stable while out_valid && !out_ready.
- Operand a = input 0, b = input 1. All arithmetic is modulo 2^DATA_WIDTH.
  - 0 PASS: a.
  - 1 ADD: a+b.
  - 2 SUB: a-b.
  - 3 AND, 4 OR, 5 XOR: bitwise a,b.
  - 6 SLL: a << b[log2(DATA_WIDTH)-1:0].
  - 7 SRL (logical): a >> b[log2(DATA_WIDTH)-1:0].
  - 8 ACC: acc <= acc+a; result = new acc value.
  - 9 SUMALL: sum of all enabled inputs.
- Config validity:
  - Ops 1-7 require mask[0] and mask[1]. Ops 0 and 8 require mask[0]. Op 9 requires mask != 0.
  - Ops >= 10, or any missing required mask bit, are illegal.
- Config acceptance:
  - cfg_ready = all FIFOs empty && !out_valid.
  - Legal cfg_valid && cfg_ready: load op and mask, acc <= cfg_acc_init, configured <= 1.
  - Illegal cfg_valid && cfg_ready: state unchanged; cfg_err pulses for 1 cycle.
  - cfg_valid while !cfg_ready: ignored; no err pulse.
- Flush:
  - Next cycle: FIFOs empty, out_valid=0.
  - op, mask, acc, configured and fire_count are retained.
  - Pushes and fire in the flush cycle are dropped.
- Before the first legal config: nothing fires and all inputs are discarded (mask=0).
- Reset asserted mid-operation clears state immediately, regardless of clk.

Test Plan:
- Cfg ADD, mask=2'b11; push 5 on ch0 and 7 on ch1 in cycle 0, out_ready=1 -> out_data=12, out_valid=1 in cycle 2, fire_count=1.
- Cfg SUB; ch0 gets 10,20,30 back-to-back, ch1 gets 1,2,3 delayed 3 cycles -> outputs 9,18,27 in order, no extra results; ch0 in_ready=0 once FIFO_DEPTH entries are queued.
- Cfg ACC, init=100, mask=01; push 1,2,3 with out_ready=1 -> outputs 101,103,106; ch1 in_ready stays 1 and its data is ignored.
- out_ready=0 for 5 cycles with ADD inputs streaming -> out_data stable, FIFOs fill, in_ready drops; on release, one result per cycle with no loss or duplication.
- cfg_op=12 while idle -> cfg_err pulse, op unchanged. cfg_valid while a FIFO is non-empty -> ignored. flush with 3 queued entries -> out_valid=0, cfg_ready=1 next cycle, fire_count unchanged.
- Assert rst asynchronously between clock edges mid-stream -> out_valid=0 and fire_count=0 immediately; no fire after deassert until reconfigured.
